mem_rd_arb: RTL and testbench

- Arbitrates one shared single-read-port memory between instruction fetch (pc/if stage) and data loads (id stage load request plus computed address).
- Sequences each read as an explicit request/response transaction.
- Raises a pipeline stall while a load is outstanding.
- Discards fetch data that a jump has flushed, and recovers from a memory that never answers via a timeout.

---
 rtl/mem_rd_arb_pkg.sv | 18 +
 rtl/mem_rd_arb_if.sv | 38 +++
 rtl/mem_rd_timer.sv | 28 ++
 rtl/mem_rd_arb.sv | 122 ++++++++++++
 tb/tb_mem_rd_arb.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mem_rd_arb_pkg.sv
// Shared types and constants for the memory read arbiter.
package mem_rd_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_BUSY = 2'd1,
    ARB_LD_BUSY = 2'd2,
    ARB_IF_DROP = 2'd3
  } arb_state_e;

  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

  // Any non-idle state has a read outstanding at the memory.
  function automatic logic is_waiting(arb_state_e s);
    return s != ARB_IDLE;
  endfunction

endpackage

// File: rtl/mem_rd_arb_if.sv
// Fetch, load and memory read-port signals of the arbiter, bundled as one interface.
interface mem_rd_arb_if;

  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;

  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic        ld_gnt_o;
  logic        ld_rvalid_o;
  logic [31:0] ld_rdata_o;

  logic        flush_i;

  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        stall_o;
  logic        err_o;

  modport slave (
    input  if_req_i, if_addr_i, ld_req_i, ld_addr_i, flush_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, ld_gnt_o, ld_rvalid_o, ld_rdata_o,
           mem_req_o, mem_addr_o, stall_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, ld_req_i, ld_addr_i, flush_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, ld_gnt_o, ld_rvalid_o, ld_rdata_o,
           mem_req_o, mem_addr_o, stall_o, err_o
  );

endinterface

// File: rtl/mem_rd_timer.sv
// Clearable wait counter; flags the cycle whose increment would reach TIMEOUT-1.
module mem_rd_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign expired_o = en && (cnt_inc == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_inc;
  end

endmodule

// File: rtl/mem_rd_arb.sv
// Shares one single-read-port memory between instruction fetch and data loads,
// one transaction at a time, with flush discard and timeout recovery.
module mem_rd_arb
  import mem_rd_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input logic          clk,
  input logic          rst_n,
  mem_rd_arb_if.slave  bus
);

  arb_state_e  state_q;
  logic        last_ld_q;
  logic        if_rvalid_q, ld_rvalid_q, err_q;
  logic [31:0] if_rdata_q, ld_rdata_q;

  logic ld_win, if_win;
  logic tmr_clr, tmr_en, expired;

  // Load normally wins; after a completed load a waiting fetch gets one turn.
  assign ld_win = bus.ld_req_i && !(bus.if_req_i && last_ld_q);
  assign if_win = bus.if_req_i && !ld_win;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bus.if_gnt_o   = 1'b0;
    bus.ld_gnt_o   = 1'b0;
    bus.mem_req_o  = 1'b0;
    bus.mem_addr_o = WORD_ZERO;
    if (state_q == ARB_IDLE) begin
      bus.ld_gnt_o  = ld_win;
      bus.if_gnt_o  = if_win;
      bus.mem_req_o = ld_win || if_win;
      if (ld_win)      bus.mem_addr_o = bus.ld_addr_i;
      else if (if_win) bus.mem_addr_o = bus.if_addr_i;
    end
  end

  assign bus.stall_o     = (bus.ld_req_i || (state_q == ARB_LD_BUSY)) && !ld_rvalid_q;
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ld_rvalid_o = ld_rvalid_q;
  assign bus.ld_rdata_o  = ld_rdata_q;
  assign bus.err_o       = err_q;

  // Held at zero while idle, restarted when a flush moves the fetch into IF_DROP.
  assign tmr_clr = (state_q == ARB_IDLE) ||
                   ((state_q == ARB_IF_BUSY) && bus.flush_i && !bus.mem_rvalid_i);
  assign tmr_en  = is_waiting(state_q) && !bus.mem_rvalid_i;

  mem_rd_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      last_ld_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= WORD_ZERO;
      ld_rdata_q  <= WORD_ZERO;
    end else begin
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (ld_win)      state_q <= ARB_LD_BUSY;
          else if (if_win) state_q <= ARB_IF_BUSY;
        end
        ARB_IF_BUSY: begin
          // A response always beats a coincident timeout; flush only gates delivery.
          if (bus.mem_rvalid_i) begin
            if (!bus.flush_i) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.mem_rdata_i;
              last_ld_q   <= 1'b0;
            end
            state_q <= ARB_IDLE;
          end else if (expired) begin
            err_q   <= 1'b1;
            state_q <= ARB_IDLE;
          end else if (bus.flush_i) begin
            state_q <= ARB_IF_DROP;
          end
        end
        ARB_LD_BUSY: begin
          if (bus.mem_rvalid_i) begin
            ld_rvalid_q <= 1'b1;
            ld_rdata_q  <= bus.mem_rdata_i;
            last_ld_q   <= 1'b1;
            state_q     <= ARB_IDLE;
          end else if (expired) begin
            err_q   <= 1'b1;
            state_q <= ARB_IDLE;
          end
        end
        ARB_IF_DROP: begin
          if (bus.mem_rvalid_i) begin
            state_q <= ARB_IDLE;
          end else if (expired) begin
            err_q   <= 1'b1;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_arb.sv
// Directed bench for mem_rd_arb: fetch, collision, flush, timeout and mid-transaction reset.
module tb_mem_rd_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_asserts = 0;
  int   n_fails   = 0;

  mem_rd_arb_if bus ();

  mem_rd_arb #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change there and outputs are sampled 1 ns later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = 32'h0;
    bus.ld_req_i     = 1'b0;
    bus.ld_addr_i    = 32'h0;
    bus.flush_i      = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;

    // Reset state
    step(); step(); #1;
    check("rst_mem_req",   bus.mem_req_o,   0);
    check("rst_mem_addr",  bus.mem_addr_o,  0);
    check("rst_stall",     bus.stall_o,     0);
    check("rst_if_rvalid", bus.if_rvalid_o, 0);
    check("rst_ld_rvalid", bus.ld_rvalid_o, 0);
    check("rst_err",       bus.err_o,       0);
    check("rst_if_rdata",  bus.if_rdata_o,  0);
    check("rst_ld_rdata",  bus.ld_rdata_o,  0);

    // Fetch only, 1-cycle memory
    step(); rst_n = 1'b1;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0000_0010; #1;
    check("f_if_gnt",   bus.if_gnt_o,   1);
    check("f_ld_gnt",   bus.ld_gnt_o,   0);
    check("f_mem_req",  bus.mem_req_o,  1);
    check("f_mem_addr", bus.mem_addr_o, 32'h10);
    check("f_stall0",   bus.stall_o,    0);
    step(); bus.if_req_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0050_0093; #1;
    check("f_busy_req", bus.mem_req_o,   0);
    check("f_no_early", bus.if_rvalid_o, 0);
    check("f_stall1",   bus.stall_o,     0);
    step(); bus.mem_rvalid_i = 1'b0; #1;
    check("f_rvalid",   bus.if_rvalid_o, 1);
    check("f_rdata",    bus.if_rdata_o,  32'h0050_0093);
    check("f_stall2",   bus.stall_o,     0);
    step(); #1;
    check("f_pulse_end", bus.if_rvalid_o, 0);
    check("f_rdata_hold", bus.if_rdata_o, 32'h0050_0093);

    // Load vs fetch collision, then alternation via last_ld
    step();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0000_0020;
    bus.ld_req_i = 1'b1; bus.ld_addr_i = 32'h0000_0100; #1;
    check("c_ld_gnt",   bus.ld_gnt_o,   1);
    check("c_if_gnt",   bus.if_gnt_o,   0);
    check("c_mem_addr", bus.mem_addr_o, 32'h100);
    check("c_stall",    bus.stall_o,    1);
    step();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEAD_BEEF; #1;
    check("c_busy_stall", bus.stall_o,   1);
    check("c_busy_req",   bus.mem_req_o, 0);
    check("c_busy_ifgnt", bus.if_gnt_o,  0);
    step(); bus.mem_rvalid_i = 1'b0; #1;
    check("c_ld_rvalid", bus.ld_rvalid_o, 1);
    check("c_ld_rdata",  bus.ld_rdata_o,  32'hDEAD_BEEF);
    check("c_stall_rel", bus.stall_o,     0);
    check("c_if_turn",   bus.if_gnt_o,    1);
    check("c_ld_wait",   bus.ld_gnt_o,    0);
    check("c_if_addr",   bus.mem_addr_o,  32'h20);
    step(); bus.if_req_i = 1'b0; bus.ld_addr_i = 32'h0000_0104;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1111_1111; #1;
    check("c_ld_pending_stall", bus.stall_o,  1);
    check("c_no_gnt_busy",      bus.ld_gnt_o, 0);
    step(); bus.mem_rvalid_i = 1'b0; #1;
    check("c_if_rvalid", bus.if_rvalid_o, 1);
    check("c_if_rdata",  bus.if_rdata_o,  32'h1111_1111);
    check("c_ld_again",  bus.ld_gnt_o,    1);
    check("c_ld_addr2",  bus.mem_addr_o,  32'h104);
    step(); bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h2222_2222;
    step(); bus.mem_rvalid_i = 1'b0; bus.ld_req_i = 1'b0; #1;
    check("c_ld_rvalid2", bus.ld_rvalid_o, 1);
    check("c_ld_rdata2",  bus.ld_rdata_o,  32'h2222_2222);
    check("c_stall_off",  bus.stall_o,     0);
    step(); #1;
    check("c_ld_pulse_end", bus.ld_rvalid_o, 0);

    // Flush one cycle after grant, 3-cycle memory
    step(); bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0000_0030; #1;
    check("fl_gnt", bus.if_gnt_o, 1);
    step(); bus.if_req_i = 1'b0; bus.flush_i = 1'b1;
    step(); bus.flush_i = 1'b0; #1;
    check("fl_drop_req",    bus.mem_req_o,   0);
    check("fl_drop_stall",  bus.stall_o,     0);
    step(); bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hBAD0_BAD0;
    step(); bus.mem_rvalid_i = 1'b0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0000_0040; #1;
    check("fl_no_pulse",  bus.if_rvalid_o, 0);
    check("fl_rdata_old", bus.if_rdata_o,  32'h1111_1111);
    check("fl_no_err",    bus.err_o,       0);
    check("fl_idle_gnt",  bus.if_gnt_o,    1);
    check("fl_idle_addr", bus.mem_addr_o,  32'h40);

    // Flush coincident with the response
    step(); bus.if_req_i = 1'b0; bus.flush_i = 1'b1;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFE_0000;
    step(); bus.flush_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    bus.ld_req_i = 1'b1; bus.ld_addr_i = 32'h0000_0200; #1;
    check("fc_no_pulse",  bus.if_rvalid_o, 0);
    check("fc_rdata_old", bus.if_rdata_o,  32'h1111_1111);
    check("fc_idle_gnt",  bus.ld_gnt_o,    1);
    check("fc_idle_addr", bus.mem_addr_o,  32'h200);

    // Timeout (TIMEOUT=4): load granted above, memory silent
    for (int i = 1; i <= 3; i++) begin
      step(); #1;
      check("to_wait_err",   bus.err_o,       0);
      check("to_wait_stall", bus.stall_o,     1);
    end
    step(); bus.ld_req_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5555_5555; #1;
    check("to_err",       bus.err_o,       1);
    check("to_no_rvalid", bus.ld_rvalid_o, 0);
    check("to_idle",      bus.stall_o,     0);
    step(); bus.mem_rvalid_i = 1'b0; #1;
    check("to_err_end",   bus.err_o,       0);
    check("to_late_ign",  bus.ld_rvalid_o, 0);
    check("to_rdata_old", bus.ld_rdata_o,  32'h2222_2222);

    // Reset during LD_BUSY
    step(); bus.ld_req_i = 1'b1; bus.ld_addr_i = 32'h0000_0300; #1;
    check("r_gnt", bus.ld_gnt_o, 1);
    step(); rst_n = 1'b0; #1;
    check("r_busy_stall", bus.stall_o, 1);
    step(); bus.ld_req_i = 1'b0; #1;
    check("r_stall",     bus.stall_o,     0);
    check("r_mem_req",   bus.mem_req_o,   0);
    check("r_ld_rdata",  bus.ld_rdata_o,  0);
    check("r_if_rdata",  bus.if_rdata_o,  0);
    check("r_ld_rvalid", bus.ld_rvalid_o, 0);
    check("r_err",       bus.err_o,       0);
    bus.ld_req_i = 1'b1; #1;
    check("r_stall_follow", bus.stall_o,   1);
    check("r_idle_req",     bus.mem_req_o, 1);
    bus.ld_req_i = 1'b0;
    step(); rst_n = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h7777_7777; #1;
    check("r_stall_rel", bus.stall_o, 0);
    step(); bus.mem_rvalid_i = 1'b0; #1;
    check("r_late_ign", bus.ld_rvalid_o, 0);
    check("r_late_rd",  bus.ld_rdata_o,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
